uart_cmd_decoder: RTL and testbench

- Sits directly downstream of uart_rx and consumes its received byte stream (readdata/done).
- Assembles fixed-format command frames for the bus arbiter: sync 0x7E, opcode, address, data.
- Presents each complete frame on a valid/ready interface and flags malformed or stalled frames.

---
 rtl/uart_cmd_decoder.sv | 150 +++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - frames uart_rx bytes (sync, opcode, addr, data) into a valid/ready command.
// Optional checksum byte (opcode ^ addr ^ data) when UART_CMD_CHECKSUM_EN is defined.
module uart_cmd_decoder #(
    parameter logic [7:0] SYNC_BYTE      = 8'h7E,
    parameter int         TIMEOUT_CYCLES = 52080,
    parameter int         TIMEOUT_W      = 16
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_done,
    output logic [7:0] o_cmd_opcode,
    output logic [7:0] o_cmd_addr,
    output logic [7:0] o_cmd_data,
    output logic       o_cmd_valid,
    input  logic       i_cmd_ready,
    output logic       o_frame_error,
    output logic       o_overrun
);

`ifdef UART_CMD_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_OPC, S_ADR, S_DAT, S_CHK, S_HOLD} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_OPC, S_ADR, S_DAT, S_HOLD} state_t;
`endif

    state_t               r_state;
    logic                 r_rx_done_q;
    logic [TIMEOUT_W-1:0] r_timer;
    logic [7:0]           r_opc;
    logic [7:0]           r_adr;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]           r_dat;
`endif

    logic w_strb;
    logic w_expired;
    logic w_in_frame;

    // A held-high done produces a single strobe on its rising edge.
    assign w_strb    = i_rx_done & ~r_rx_done_q;
    assign w_expired = (r_timer == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
`ifdef UART_CMD_CHECKSUM_EN
    assign w_in_frame = (r_state == S_OPC) || (r_state == S_ADR) ||
                        (r_state == S_DAT) || (r_state == S_CHK);
`else
    assign w_in_frame = (r_state == S_OPC) || (r_state == S_ADR) ||
                        (r_state == S_DAT);
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_rx_done_q   <= 1'b0;
            r_timer       <= '0;
            r_opc         <= 8'h00;
            r_adr         <= 8'h00;
`ifdef UART_CMD_CHECKSUM_EN
            r_dat         <= 8'h00;
`endif
            o_cmd_opcode  <= 8'h00;
            o_cmd_addr    <= 8'h00;
            o_cmd_data    <= 8'h00;
            o_cmd_valid   <= 1'b0;
            o_frame_error <= 1'b0;
            o_overrun     <= 1'b0;
        end else begin
            r_rx_done_q   <= i_rx_done;
            o_frame_error <= 1'b0;
            o_overrun     <= 1'b0;

            // Inter-byte watchdog; a strobe in the expiry cycle takes priority.
            if (w_in_frame) begin
                if (w_strb) begin
                    r_timer <= '0;
                end else if (w_expired) begin
                    r_timer       <= '0;
                    o_frame_error <= 1'b1;
                    r_state       <= S_IDLE;
                end else begin
                    r_timer <= r_timer + TIMEOUT_W'(1);
                end
            end else begin
                r_timer <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_strb && (i_rx_data == SYNC_BYTE))
                        r_state <= S_OPC;
                end
                S_OPC: begin
                    if (w_strb) begin
                        r_opc   <= i_rx_data;
                        r_state <= S_ADR;
                    end
                end
                S_ADR: begin
                    if (w_strb) begin
                        r_adr   <= i_rx_data;
                        r_state <= S_DAT;
                    end
                end
`ifdef UART_CMD_CHECKSUM_EN
                S_DAT: begin
                    if (w_strb) begin
                        r_dat   <= i_rx_data;
                        r_state <= S_CHK;
                    end
                end
                S_CHK: begin
                    if (w_strb) begin
                        if (i_rx_data == (r_opc ^ r_adr ^ r_dat)) begin
                            o_cmd_opcode <= r_opc;
                            o_cmd_addr   <= r_adr;
                            o_cmd_data   <= r_dat;
                            o_cmd_valid  <= 1'b1;
                            r_state      <= S_HOLD;
                        end else begin
                            o_frame_error <= 1'b1;
                            r_state       <= S_IDLE;
                        end
                    end
                end
`else
                S_DAT: begin
                    if (w_strb) begin
                        o_cmd_opcode <= r_opc;
                        o_cmd_addr   <= r_adr;
                        o_cmd_data   <= i_rx_data;
                        o_cmd_valid  <= 1'b1;
                        r_state      <= S_HOLD;
                    end
                end
`endif
                S_HOLD: begin
                    // Bytes arriving while a frame is held are dropped, including on the transfer cycle.
                    if (w_strb)
                        o_overrun <= 1'b1;
                    if (i_cmd_ready) begin
                        o_cmd_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - scoreboard bench for uart_cmd_decoder.
module tb_uart_cmd_decoder;

    localparam int BIT_T = 52;
    localparam int T     = BIT_T * 10;
    localparam int TW    = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       cmd_ready = 1'b1;
    logic [7:0] cmd_opcode, cmd_addr, cmd_data;
    logic       cmd_valid, frame_error, overrun;

    uart_cmd_decoder #(.SYNC_BYTE(8'h7E), .TIMEOUT_CYCLES(T), .TIMEOUT_W(TW)) dut (
        .i_clock(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
        .o_cmd_opcode(cmd_opcode), .o_cmd_addr(cmd_addr), .o_cmd_data(cmd_data),
        .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready),
        .o_frame_error(frame_error), .o_overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] o;
        logic [7:0] a;
        logic [7:0] d;
    } frame_t;

    frame_t exp_q[$];
    int n_vec  = 0;
    int n_miss = 0;
    int n_fe   = 0;
    int n_ov   = 0;
    logic prev_fe = 1'b0;
    logic prev_ov = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid && cmd_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL unexpected_frame got %h/%h/%h required none", cmd_opcode, cmd_addr, cmd_data);
                end else begin
                    frame_t e;
                    e = exp_q.pop_front();
                    if ({cmd_opcode, cmd_addr, cmd_data} !== e) begin
                        n_miss++;
                        $display("FAIL frame got %h/%h/%h required %h/%h/%h",
                                 cmd_opcode, cmd_addr, cmd_data, e.o, e.a, e.d);
                    end
                end
            end
            if (frame_error) begin
                n_fe++;
                n_vec++;
                if (prev_fe) begin
                    n_miss++;
                    $display("FAIL frame_error_width got 2+ cycles required 1");
                end
            end
            if (overrun) begin
                n_ov++;
                n_vec++;
                if (prev_ov) begin
                    n_miss++;
                    $display("FAIL overrun_width got 2+ cycles required 1");
                end
            end
        end
        prev_fe = frame_error;
        prev_ov = overrun;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Rising edges of rx_done are spaced exactly gap cycles apart.
    task automatic send(input logic [7:0] b, input int hold, input int gap);
        rx_data = b;
        rx_done = 1'b1;
        repeat (hold) step();
        rx_done = 1'b0;
        repeat (gap - hold) step();
    endtask

    task automatic send_frame(input logic [7:0] o, input logic [7:0] a, input logic [7:0] d,
                              input int hold, input int gap);
        send(8'h7E, hold, gap);
        send(o, hold, gap);
        send(a, hold, gap);
        send(d, hold, gap);
`ifdef UART_CMD_CHECKSUM_EN
        send(o ^ a ^ d, hold, gap);
`endif
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        repeat (3) step();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL %s_drain got %0d pending required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk_delta(input string name, input int got, input int req);
        n_vec++;
        if (got !== req) begin
            n_miss++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        n_vec++;
        if ({cmd_opcode, cmd_addr, cmd_data, cmd_valid, frame_error, overrun} !== 27'h0) begin
            n_miss++;
            $display("FAIL %s got %h/%h/%h v=%b fe=%b ov=%b required all 0",
                     name, cmd_opcode, cmd_addr, cmd_data, cmd_valid, frame_error, overrun);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        chk_idle_outputs("reset_outputs");
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int fe0 = n_fe, ov0 = n_ov;
        cmd_ready = 1'b1;
        exp_q.push_back({8'h01, 8'h20, 8'hAB});
        send_frame(8'h01, 8'h20, 8'hAB, 1, 4);
        wait_drain("basic");
        chk_delta("basic_frame_error", n_fe - fe0, 0);
        chk_delta("basic_overrun", n_ov - ov0, 0);
        chk_delta("basic_valid_low", int'(cmd_valid), 0);
    endtask

    task automatic test_sync_payload();
        send(8'h55, 1, 4);
        exp_q.push_back({8'h02, 8'h7E, 8'hCC});
        send_frame(8'h02, 8'h7E, 8'hCC, 1, 4);
        wait_drain("sync_payload");
    endtask

    task automatic test_timeout();
        int fe0 = n_fe;
        send(8'h7E, 1, 4);
        send(8'h03, 1, 4);
        send(8'h10, 1, 4);
        repeat (T + 4) step();
        chk_delta("timeout_error", n_fe - fe0, 1);
        chk_delta("timeout_valid_low", int'(cmd_valid), 0);
        exp_q.push_back({8'h04, 8'h11, 8'h22});
        send_frame(8'h04, 8'h11, 8'h22, 1, 4);
        wait_drain("after_timeout");
    endtask

    task automatic test_timeout_boundary();
        int fe0 = n_fe;
        exp_q.push_back({8'h0C, 8'h0D, 8'h0E});
        send_frame(8'h0C, 8'h0D, 8'h0E, 1, T);
        wait_drain("gap_equal_timeout");
        chk_delta("gap_equal_timeout_error", n_fe - fe0, 0);
        fe0 = n_fe;
        send(8'h7E, 1, T + 1);
        send(8'h08, 1, 4);
        send(8'h09, 1, 4);
        send(8'h0A, 1, 4);
        repeat (6) step();
        chk_delta("gap_over_timeout_error", n_fe - fe0, 1);
        chk_delta("gap_over_timeout_valid", int'(cmd_valid), 0);
    endtask

    task automatic test_overrun();
        int ov0 = n_ov;
        cmd_ready = 1'b0;
        exp_q.push_back({8'h05, 8'h30, 8'h40});
        send_frame(8'h05, 8'h30, 8'h40, 1, 4);
        send(8'h99, 1, 4);
        chk_delta("overrun_pulse", n_ov - ov0, 1);
        n_vec++;
        if ({cmd_valid, cmd_opcode, cmd_addr, cmd_data} !== {1'b1, 8'h05, 8'h30, 8'h40}) begin
            n_miss++;
            $display("FAIL overrun_hold got v=%b %h/%h/%h required v=1 05/30/40",
                     cmd_valid, cmd_opcode, cmd_addr, cmd_data);
        end
        cmd_ready = 1'b1;
        wait_drain("overrun");
        chk_delta("overrun_valid_low", int'(cmd_valid), 0);
    endtask

    task automatic test_xfer_overrun();
        int ov0 = n_ov;
        cmd_ready = 1'b0;
        exp_q.push_back({8'h0F, 8'h10, 8'h11});
        send_frame(8'h0F, 8'h10, 8'h11, 1, 4);
        cmd_ready = 1'b1;
        send(8'h7E, 1, 4);
        chk_delta("xfer_overrun_pulse", n_ov - ov0, 1);
        send(8'h21, 1, 4);
        send(8'h22, 1, 4);
        send(8'h23, 1, 4);
`ifdef UART_CMD_CHECKSUM_EN
        send(8'h21 ^ 8'h22 ^ 8'h23, 1, 4);
`endif
        wait_drain("xfer_overrun");
        chk_delta("xfer_overrun_no_frame", int'(cmd_valid), 0);
    endtask

    task automatic test_held_done();
        int fe0 = n_fe;
        exp_q.push_back({8'hAA, 8'hAB, 8'hAC});
        send_frame(8'hAA, 8'hAB, 8'hAC, 100, T);
        wait_drain("held_done");
        chk_delta("held_done_error", n_fe - fe0, 0);
    endtask

    task automatic test_reset_mid();
        send(8'h7E, 1, 4);
        send(8'h06, 1, 4);
        rst = 1'b1;
        step();
        step();
        chk_idle_outputs("reset_mid_outputs");
        rst = 1'b0;
        step();
        exp_q.push_back({8'h07, 8'h08, 8'h09});
        send_frame(8'h07, 8'h08, 8'h09, 1, 4);
        wait_drain("after_reset");
    endtask

`ifdef UART_CMD_CHECKSUM_EN
    task automatic test_checksum();
        int fe0 = n_fe;
        exp_q.push_back({8'h01, 8'h02, 8'h03});
        send(8'h7E, 1, 4); send(8'h01, 1, 4); send(8'h02, 1, 4); send(8'h03, 1, 4); send(8'h00, 1, 4);
        wait_drain("checksum_ok");
        send(8'h7E, 1, 4); send(8'h01, 1, 4); send(8'h02, 1, 4); send(8'h03, 1, 4); send(8'hFF, 1, 4);
        repeat (6) step();
        chk_delta("checksum_bad_error", n_fe - fe0, 1);
        chk_delta("checksum_bad_valid", int'(cmd_valid), 0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_sync_payload();
        test_timeout();
        test_timeout_boundary();
        test_overrun();
        test_xfer_overrun();
        test_held_done();
        test_reset_mid();
`ifdef UART_CMD_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
